// File: rtl/x_dl_pkg.sv
// Shared types and constants for the delay-line measurement sequencer.
package x_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [31:0] DL_POL = 32'hAAAA_AAAA;

  localparam int EDGE_W = 6;
  localparam int SUM_W  = 14;
  localparam int BUB_W  = 9;

endpackage

// File: rtl/x_dl_edge_decode.sv
// Snapshot normaliser: thermometer edge position plus bubble flag.
module x_dl_edge_decode
  import x_dl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]      i_data,
  output logic [EDGE_W-1:0] o_edge,
  output logic              o_bubble
);

  localparam logic [W-1:0] POL = W'(DL_POL);

  logic [W-1:0] n;
  logic         seen0;

  assign n = i_data ^ POL;

  // Ones below the first zero give the edge; any one above it is a bubble.
  always_comb begin
    o_edge   = '0;
    o_bubble = 1'b0;
    seen0    = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (!seen0) begin
        if (n[i]) begin
          o_edge = EDGE_W'(i + 1);
        end else begin
          seen0 = 1'b1;
        end
      end else if (n[i]) begin
        o_bubble = 1'b1;
      end
    end
  end

endmodule

// File: rtl/x_dl_sequencer.sv
// Batch sequencer: flush, accumulate min/max/sum/bubbles over 2^N
// delay-line samples, then hold the result for a valid/ack readout.
module x_dl_sequencer
  import x_dl_pkg::*;
#(
  parameter int W     = 32,
  parameter int FLUSH = 2,
  parameter int MAXL  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [W-1:0]      i_data,
  input  logic              i_start,
  input  logic [3:0]        i_log2n,
  input  logic              i_abort,
  input  logic              i_ack,
  output logic              o_busy,
  output logic              o_valid,
  output logic [EDGE_W-1:0] o_min,
  output logic [EDGE_W-1:0] o_max,
  output logic [EDGE_W-1:0] o_mean,
  output logic [SUM_W-1:0]  o_sum,
  output logic [BUB_W-1:0]  o_bubbles
);

  localparam int CNT_W = MAXL + 1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         log2_q, log2_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [EDGE_W-1:0]  min_q, min_d;
  logic [EDGE_W-1:0]  max_q, max_d;
  logic [EDGE_W-1:0]  mean_q, mean_d;
  logic [BUB_W-1:0]   bub_q, bub_d;

  logic [EDGE_W-1:0]  edge_pos;
  logic               bubble;
  logic [3:0]         log2_clamp;
  logic [CNT_W-1:0]   run_last;

  x_dl_edge_decode #(
    .W(W)
  ) u_dec (
    .i_data  (i_data),
    .o_edge  (edge_pos),
    .o_bubble(bubble)
  );

  assign log2_clamp = (i_log2n > 4'(MAXL)) ? 4'(MAXL) : i_log2n;
  assign run_last   = CNT_W'((32'd1 << log2_q) - 32'd1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      log2_q  <= '0;
      sum_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      mean_q  <= '0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      log2_q  <= log2_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      mean_q  <= mean_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    log2_d  = log2_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    mean_d  = mean_q;
    bub_d   = bub_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
          log2_d  = log2_clamp;
          sum_d   = '0;
          bub_d   = '0;
          min_d   = '1;
          max_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == FLUSH_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          state_d = ST_IDLE;
        end else begin
          sum_d = sum_q + SUM_W'(edge_pos);
          bub_d = bub_q + BUB_W'(bubble);
          cnt_d = cnt_q + 1'b1;
          if (edge_pos < min_q) min_d = edge_pos;
          if (edge_pos > max_q) max_d = edge_pos;
          // Mean uses the sum including this final sample.
          if (cnt_q == run_last) begin
            state_d = ST_DONE;
            mean_d  = EDGE_W'(sum_d >> log2_q);
          end
        end
      end
      ST_DONE: begin
        if (i_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy    = (state_q == ST_FLUSH) || (state_q == ST_RUN);
  assign o_valid   = (state_q == ST_DONE);
  assign o_min     = min_q;
  assign o_max     = max_q;
  assign o_mean    = mean_q;
  assign o_sum     = sum_q;
  assign o_bubbles = bub_q;

endmodule

// File: tb/tb_x_dl_sequencer.sv
// Scoreboard bench for the delay-line sequencer.
module tb_x_dl_sequencer;

  localparam logic [31:0] POL = 32'hAAAA_AAAA;
  localparam int FL = 2;
  localparam int MX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        start, abort, ack;
  logic [3:0]  lg;
  logic        busy, valid;
  logic [5:0]  mn, mx, mean;
  logic [13:0] sum;
  logic [8:0]  bub;

  typedef struct {
    int cyc;
    int mn;
    int mx;
    int sum;
    int mean;
    int bub;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] dq[$];
  int          vecs = 0;
  int          errs = 0;

  x_dl_sequencer #(.W(32), .FLUSH(FL), .MAXL(MX)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_data   (din),
    .i_start  (start),
    .i_log2n  (lg),
    .i_abort  (abort),
    .i_ack    (ack),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_min    (mn),
    .o_max    (mx),
    .o_mean   (mean),
    .o_sum    (sum),
    .o_bubbles(bub)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int edge_of(logic [31:0] n);
    int e = 0;
    while (e < 32 && n[e]) e++;
    return e;
  endfunction

  function automatic logic [31:0] thermo(int e, bit bb);
    logic [31:0] n;
    n = (e >= 32) ? 32'hFFFF_FFFF : ((32'd1 << e) - 32'd1);
    if (bb && e < 30) n[e + 1 + ($urandom % (31 - e))] = 1'b1;
    return n ^ POL;
  endfunction

  function automatic exp_t model(int l);
    exp_t r;
    int   nn, e;
    logic [31:0] n;
    int   k = (l > MX) ? MX : l;
    nn = 1 << k;
    r.cyc = FL + nn + 1;
    r.mn = 63; r.mx = 0; r.sum = 0; r.bub = 0;
    for (int i = FL; i < FL + nn; i++) begin
      n = dq[i] ^ POL;
      e = edge_of(n);
      r.sum += e;
      if (e < r.mn) r.mn = e;
      if (e > r.mx) r.mx = e;
      if (e < 31 && (n >> (e + 1)) != 0) r.bub++;
    end
    r.mean = r.sum / nn;
    return r;
  endfunction

  task automatic run_batch(input int l, input int ack_dly,
                           input bit poke, input string nm);
    exp_t e;
    int   cyc;
    bit   seen, hold_ok;
    sb.push_back(model(l));
    lg = 4'(l); start = 1'b1; din = $urandom;
    tick();
    start = 1'b0;
    cyc = 1;
    vecs++;
    if (busy !== 1'b1) begin
      errs++; $display("FAIL %s busy: got %b want 1", nm, busy);
    end
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      din = (cyc - 1 < dq.size()) ? dq[cyc - 1] : $urandom;
      tick();
      cyc++;
      if (valid === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    vecs++;
    if (!seen) begin
      errs++; $display("FAIL %s timeout: no valid in %0d cycles", nm, cyc);
      return;
    end
    if (cyc !== e.cyc) begin
      errs++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, e.cyc);
    end
    vecs++;
    if (int'(mn) !== e.mn) begin
      errs++; $display("FAIL %s min: got %0d want %0d", nm, mn, e.mn);
    end
    vecs++;
    if (int'(mx) !== e.mx) begin
      errs++; $display("FAIL %s max: got %0d want %0d", nm, mx, e.mx);
    end
    vecs++;
    if (int'(sum) !== e.sum) begin
      errs++; $display("FAIL %s sum: got %0d want %0d", nm, sum, e.sum);
    end
    vecs++;
    if (int'(mean) !== e.mean) begin
      errs++; $display("FAIL %s mean: got %0d want %0d", nm, mean, e.mean);
    end
    vecs++;
    if (int'(bub) !== e.bub) begin
      errs++; $display("FAIL %s bubbles: got %0d want %0d", nm, bub, e.bub);
    end
    hold_ok = 1'b1;
    for (int k = 0; k < ack_dly; k++) begin
      din = $urandom;
      start = poke && (k == 3);
      tick();
      start = 1'b0;
      if (valid !== 1'b1 || busy !== 1'b0 || int'(sum) !== e.sum)
        hold_ok = 1'b0;
    end
    vecs++;
    if (!hold_ok) begin
      errs++; $display("FAIL %s hold: valid=%b busy=%b sum=%0d want 1/0/%0d",
                       nm, valid, busy, sum, e.sum);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    vecs++;
    if (valid !== 1'b0) begin
      errs++; $display("FAIL %s ack: valid got %b want 0", nm, valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; ack = 0; lg = 0; din = 0;
    tick(); tick();
    vecs++;
    if ({busy, valid, mn, mx, mean, sum, bub} !== '0) begin
      errs++; $display("FAIL reset: b=%b v=%b min=%0d max=%0d mean=%0d sum=%0d bub=%0d want all 0",
                       busy, valid, mn, mx, mean, sum, bub);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_const();
    dq.delete();
    for (int i = 0; i < 6; i++) dq.push_back(32'hAAAA_5555);
    run_batch(2, 1, 1'b0, "const16");
  endtask

  task automatic test_flush();
    int ed[4] = '{3, 5, 7, 9};
    dq.delete();
    dq.push_back(32'h7FFF_FFFF ^ POL);
    dq.push_back(32'h7FFF_FFFF ^ POL);
    for (int i = 0; i < 4; i++) dq.push_back(thermo(ed[i], 1'b0));
    run_batch(2, 1, 1'b0, "flush");
  endtask

  task automatic test_extremes();
    dq.delete();
    dq.push_back($urandom);
    dq.push_back($urandom);
    dq.push_back(32'hFFFF_FFFF ^ POL);
    dq.push_back(32'h0000_0000 ^ POL);
    dq.push_back(32'h000F_00FF ^ POL);
    dq.push_back(32'h000F_00FF ^ POL);
    run_batch(2, 1, 1'b0, "extremes");
  endtask

  task automatic test_handshake();
    dq.delete();
    for (int i = 0; i < 10; i++)
      dq.push_back(thermo($urandom_range(0, 32), 1'($urandom % 2)));
    run_batch(3, 20, 1'b1, "hs_hold");
    dq.delete();
    for (int i = 0; i < 4; i++) dq.push_back(thermo(i * 7, 1'b0));
    run_batch(1, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_clamp();
    dq.delete();
    for (int i = 0; i < 258; i++)
      dq.push_back(thermo($urandom_range(0, 32), 1'($urandom % 4 == 0)));
    run_batch(9, 2, 1'b0, "clamp");
  endtask

  task automatic test_abort();
    bit never;
    lg = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 50; c++) begin
      din = $urandom;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL abort busy: got %b want 0", busy);
    end
    never = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) never = 1'b0;
    end
    vecs++;
    if (!never) begin
      errs++; $display("FAIL abort idle: valid/busy raised after abort");
    end
  endtask

  task automatic test_reset_midrun();
    lg = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 7; c++) begin
      din = thermo(20, 1'b1);
      tick();
    end
    rst = 1'b1;
    #1;
    vecs++;
    if ({busy, valid, mn, mx, mean, sum, bub} !== '0) begin
      errs++; $display("FAIL rst_mid: b=%b v=%b min=%0d max=%0d sum=%0d bub=%0d want all 0",
                       busy, valid, mn, mx, sum, bub);
    end
    tick();
    vecs++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL rst_mid busy: got %b want 0", busy);
    end
    rst = 1'b0;
    tick();
    dq.delete();
    for (int i = 0; i < 10; i++) dq.push_back(thermo($urandom_range(0, 32), 1'b0));
    run_batch(3, 1, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_const();
    test_flush();
    test_extremes();
    test_handshake();
    test_clamp();
    test_abort();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/x_dl_sequencer.md
# x_dl_sequencer

Measurement sequencer for the 32-tap inverter delay line. It normalises each registered delay-line snapshot to a thermometer code and decodes the edge position (taps traversed per clock). Over a programmable batch of 2^N samples it accumulates min, max, sum, mean and a bubble count. Results are held for a host/test-harness readout with a valid/ack handshake. It sits directly downstream of the delay-line sampler's 32-bit output.

## Interface
- `W`, 32: delay-line tap count / snapshot width.
- `FLUSH`, 2: snapshots discarded after start (covers the sampler's 2-stage pipeline).
- `MAXL`, 8: maximum log2 batch size; batch ≤ 256.

- `i_clk`  in  1  sole clock; also drives the delay line.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_data`  in  W  registered delay-line snapshot.
- `i_start`  in  1  begin a batch; honoured only in IDLE.
- `i_log2n`  in  4  log2 of batch size, latched at start; values > MAXL clamp to MAXL.
- `i_abort`  in  1  return to IDLE from FLUSH/RUN, no result.
- `i_ack`  in  1  consume result in DONE.
- `o_busy`  out  1  high in FLUSH or RUN.
- `o_valid`  out  1  high in DONE.
- `o_min`, `o_max`, `o_mean`  out  6  edge statistics, range 0..32.
- `o_sum`  out  14  sum of edges over the batch.
- `o_bubbles`  out  9  count of snapshots with a non-monotonic code.

## Operation
- Normalise: `n = i_data ^ 32'hAAAA_AAAA`. Odd taps are inverted, so a clean snapshot is a thermometer code: ones from bit 0 up, then zeros.
- Edge position = number of consecutive ones from bit 0 of `n`.
  - 0 if `n[0]` is 0; 32 if all ones.
- Bubble = any 1 above the first 0 in `n`. A bubble snapshot still contributes its edge position.
- FSM states: IDLE, FLUSH, RUN, DONE.
  - IDLE→FLUSH on `i_start`. On this transition: latch the clamped `log2n`; clear the sample counter, sum and bubbles; set min to 63, max to 0.
  - FLUSH: discard `i_data` for `FLUSH` cycles, then →RUN.
  - RUN: consume one snapshot per cycle and update the accumulators. After 2^log2n samples →DONE.
  - DONE: hold all outputs; →IDLE on `i_ack`.
  - `i_abort` in FLUSH/RUN →IDLE. Result registers keep their stale values, but `o_valid` is never raised. `i_abort` is ignored in IDLE/DONE.
- `o_mean = o_sum >> log2n` (floor), registered on entry to DONE.
- Priority: `i_rst` > `i_abort` > normal sequencing.
  - `i_start` is ignored in FLUSH/RUN/DONE.
  - `i_start` together with `i_ack` in DONE: the ack is taken, the start is dropped.
- Sum cannot overflow: 256 × 32 = 8192 < 2^14. Bubble count max 256 fits 9 bits.

## Timing
- Reset: state IDLE; `o_busy` = `o_valid` = 0; `o_min` = `o_max` = `o_mean` = 0; `o_sum` = 0; `o_bubbles` = 0.
- `i_start` high in cycle 0 → `o_busy` high from cycle 1.
  - FLUSH occupies cycles 1..FLUSH.
  - RUN samples `i_data` in cycles FLUSH+1..FLUSH+N (N = 2^log2n).
  - `o_valid` high from cycle FLUSH+N+1 with all results stable.
- `o_valid` stays high until the cycle after `i_ack` is sampled high. The next cycle is IDLE, so a new `i_start` is accepted no earlier than 1 cycle after ack.
- `i_abort` sampled high → IDLE next cycle, `o_busy` low.
- `i_rst` asserted mid-batch → immediate return to the reset values above.

## Structure
- Package `x_dl_pkg`:
  - state enum.
  - `DL_POL = 32'hAAAA_AAAA`.
  - widths: `EDGE_W = 6`, `SUM_W = 14`, `BUB_W = 9`.
- Sub-module `x_dl_edge_decode`: combinational; `W`-bit input → `EDGE_W` edge position + bubble flag. Verified standalone.
- Top holds the FSM, counter, accumulators and output registers.

## Test plan
- Reset mid-RUN (`log2n`=3, 4 samples in) → all outputs 0, `o_busy` 0 next cycle; a subsequent batch is unaffected.
- `i_data` = 0xAAAA5555 (n = 0x0000FFFF) constant, `log2n` = 2, start at cycle 0 → `o_valid` at cycle 7; min = max = mean = 16, sum = 64, bubbles = 0.
- Flush discard: first 2 post-start snapshots with n = 0x7FFFFFFF, then edges 3, 5, 7, 9 with `log2n` = 2 → min 3, max 9, sum 24, mean 6.
- Extremes and bubble: `log2n` = 2 with n = 0xFFFFFFFF, 0x00000000, 0x000F00FF, 0x000F00FF → min 0, max 32, sum 48, mean 12, bubbles 2.
- Handshake: `i_start` pulsed in DONE is ignored; `o_valid` holds 20 cycles until `i_ack`; start 1 cycle after ack is accepted.
- `i_log2n` = 9 clamps to 256 samples (`o_valid` at cycle 259, sum = 256 × edge); `i_abort` at cycle 50 → IDLE, `o_valid` never set.
